// File: rtl/uart_cmd_decoder_if.sv
// Byte-stream and debug/load port bundle between the UART byte engines, the command
// decoder and the imem/regfile side.
interface uart_cmd_decoder_if;
    // Handshake semantics:
    //   rx_valid     one-cycle strobe; rx_data is meaningful only while it is high, and there is
    //                no back-pressure, so a byte the decoder cannot use is lost.
    //   tx_start     one-cycle request, issued only when tx_busy was low at the sampling edge;
    //                tx_data is stable while it is high and holds the last byte sent afterwards.
    //   tx_busy      raised by the TX engine from the cycle after tx_start until the byte is out.
    //   if_out_valid one-cycle write strobe; if_addr_out and if_data_out are stable while it is high.
    //   if_data_in   sampled READ_LAT clocks after if_addr_out becomes valid.
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic [31:0] if_data_in;
    logic [31:0] if_addr_out;
    logic [31:0] if_data_out;
    logic        if_out_valid;
    logic        busy;

    modport master (
        input  rx_data, rx_valid, tx_busy, if_data_in,
        output tx_data, tx_start, if_addr_out, if_data_out, if_out_valid, busy
    );

    modport slave (
        output rx_data, rx_valid, tx_busy, if_data_in,
        input  tx_data, tx_start, if_addr_out, if_data_out, if_out_valid, busy
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// UART command decoder: assembles 'W' (imem load) and 'R' (regfile peek) packets from RX
// bytes, strobes write words out, and returns read words as four MSB-first TX bytes.
module uart_cmd_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
    parameter int unsigned READ_LAT       = 1,
    parameter logic [7:0]  CMD_WRITE      = 8'h57,
    parameter logic [7:0]  CMD_READ       = 8'h52
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_cmd_decoder_if.master    bus,
    output logic [2:0]            state_dbg
);
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int LAT_W = $clog2(READ_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_GET_ADDR  = 3'd1,
        S_GET_DATA  = 3'd2,
        S_WRITE     = 3'd3,
        S_READ_WAIT = 3'd4,
        S_SEND      = 3'd5,
        S_TX_HOLD   = 3'd6
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               is_write;
    logic [1:0]         byte_cnt;
    logic [1:0]         tx_idx;
    logic [31:0]        word;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [LAT_W-1:0]   lat_cnt;
    logic               wr_done;
    logic               tmo_hit;
    logic               lat_done;

    // The counter holds the number of idle clocks minus one, so a hit means TIMEOUT_CYCLES idle clocks.
    assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign lat_done  = (lat_cnt == LAT_W'(READ_LAT));
    assign bus.busy  = (state != S_IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.rx_valid && (bus.rx_data == CMD_WRITE || bus.rx_data == CMD_READ)) begin
                    state_nxt = S_GET_ADDR;
                end
            end
            S_GET_ADDR: begin
                if (bus.rx_valid) begin
                    state_nxt = is_write ? S_GET_DATA : S_READ_WAIT;
                end else if (tmo_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_GET_DATA: begin
                if (bus.rx_valid) begin
                    if (byte_cnt == 2'd3) begin
                        state_nxt = S_WRITE;
                    end
                end else if (tmo_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_WRITE: begin
                state_nxt = S_IDLE;
            end
            S_READ_WAIT: begin
                if (lat_done) begin
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (!bus.tx_busy) begin
                    state_nxt = S_TX_HOLD;
                end
            end
            S_TX_HOLD: begin
                state_nxt = (tx_idx == 2'd0) ? S_IDLE : S_SEND;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            is_write         <= 1'b0;
            byte_cnt         <= 2'd0;
            tx_idx           <= 2'd0;
            word             <= 32'd0;
            tmo_cnt          <= '0;
            lat_cnt          <= '0;
            wr_done          <= 1'b0;
            bus.tx_data      <= 8'd0;
            bus.tx_start     <= 1'b0;
            bus.if_addr_out  <= 32'd0;
            bus.if_data_out  <= 32'd0;
            bus.if_out_valid <= 1'b0;
        end else begin
            bus.tx_start     <= 1'b0;
            // The strobe trails the if_data_out update by one clock so the word is settled under it.
            wr_done          <= (state == S_WRITE);
            bus.if_out_valid <= wr_done;
            case (state)
                S_IDLE: begin
                    tmo_cnt  <= '0;
                    byte_cnt <= 2'd0;
                    if (bus.rx_valid) begin
                        is_write <= (bus.rx_data == CMD_WRITE);
                    end
                end
                S_GET_ADDR: begin
                    if (bus.rx_valid) begin
                        bus.if_addr_out <= {24'd0, bus.rx_data};
                        tmo_cnt         <= '0;
                        byte_cnt        <= 2'd0;
                        lat_cnt         <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                S_GET_DATA: begin
                    if (bus.rx_valid) begin
                        word     <= {word[23:0], bus.rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        tmo_cnt  <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                S_WRITE: begin
                    bus.if_data_out <= word;
                end
                S_READ_WAIT: begin
                    if (lat_done) begin
                        word   <= bus.if_data_in;
                        tx_idx <= 2'd3;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                S_SEND: begin
                    if (!bus.tx_busy) begin
                        bus.tx_data  <= word[{tx_idx, 3'b000} +: 8];
                        bus.tx_start <= 1'b1;
                    end
                end
                S_TX_HOLD: begin
                    if (tx_idx != 2'd0) begin
                        tx_idx <= tx_idx - 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: byte drivers, a TX engine model with
// configurable busy time, and a scoreboard of expected writes and TX bytes.
module tb_uart_cmd_decoder;
    localparam int unsigned TMO  = 16;
    localparam int unsigned RLAT = 2;
    localparam int          PER  = 10;

    logic clk;
    logic reset;
    logic [2:0] state_dbg;

    uart_cmd_decoder_if bus_if ();

    uart_cmd_decoder #(
        .TIMEOUT_CYCLES(TMO),
        .READ_LAT      (RLAT),
        .CMD_WRITE     (8'h57),
        .CMD_READ      (8'h52)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus_if),
        .state_dbg(state_dbg)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int busy_len = 3;
    logic [63:0] last_t;

    logic [7:0]  tx_q[$];
    logic [63:0] tx_t_q[$];
    logic [31:0] rd_addr_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [63:0] wr_t_q[$];

    logic [7:0]  exp_b;
    logic [63:0] exp_t;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #(PER / 2) clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        n_checks++;
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus_if.rx_data  = b;
        bus_if.rx_valid = 1'b1;
        @(posedge clk);
        last_t = $time;
        #1;
        bus_if.rx_valid = 1'b0;
    endtask

    task automatic send_write(input logic [7:0] a, input logic [31:0] d, input int gap);
        logic [7:0] bytes[6];
        bytes = '{8'h57, a, d[31:24], d[23:16], d[15:8], d[7:0]};
        for (int i = 0; i < 6; i++) begin
            send_byte(bytes[i]);
            if (i < 5) repeat (gap) step();
        end
        wr_addr_q.push_back({24'd0, a});
        wr_data_q.push_back(d);
        wr_t_q.push_back(last_t + 64'(2 * PER + PER / 2));
    endtask

    task automatic send_read(input logic [7:0] a, input logic [31:0] d);
        bus_if.if_data_in = d;
        send_byte(8'h52);
        send_byte(a);
        rd_addr_q.push_back({24'd0, a});
        tx_q.push_back(d[31:24]);
        tx_t_q.push_back(last_t + 64'((RLAT + 2) * PER + PER / 2));
        tx_q.push_back(d[23:16]);
        tx_t_q.push_back(64'd0);
        tx_q.push_back(d[15:8]);
        tx_t_q.push_back(64'd0);
        tx_q.push_back(d[7:0]);
        tx_t_q.push_back(64'd0);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (!bus_if.busy && !bus_if.tx_busy && tx_q.size() == 0 && wr_addr_q.size() == 0) break;
            step();
        end
        repeat (4) step();
        check({tag, "_busy"}, 64'(bus_if.busy), 64'd0);
        check({tag, "_tx_pending"}, 64'(tx_q.size()), 64'd0);
        check({tag, "_wr_pending"}, 64'(wr_addr_q.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_data"}, 64'(bus_if.tx_data), 64'd0);
        check({tag, "_tx_start"}, 64'(bus_if.tx_start), 64'd0);
        check({tag, "_if_addr_out"}, 64'(bus_if.if_addr_out), 64'd0);
        check({tag, "_if_data_out"}, 64'(bus_if.if_data_out), 64'd0);
        check({tag, "_if_out_valid"}, 64'(bus_if.if_out_valid), 64'd0);
        check({tag, "_busy"}, 64'(bus_if.busy), 64'd0);
        check({tag, "_state"}, 64'(state_dbg), 64'd0);
    endtask

    // ---------------- TX engine model ----------------
    initial begin
        bus_if.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_if.tx_start && busy_len > 0) begin
                @(posedge clk);
                #1 bus_if.tx_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 bus_if.tx_busy = 1'b0;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (bus_if.tx_start) begin
            check("tx_start_while_busy", 64'(bus_if.tx_busy), 64'd0);
            if (tx_q.size() == 0) begin
                check("tx_start_unexpected", 64'(bus_if.tx_start), 64'd0);
            end else begin
                exp_b = tx_q.pop_front();
                exp_t = tx_t_q.pop_front();
                check("tx_byte", 64'(bus_if.tx_data), 64'(exp_b));
                if (exp_t != 64'd0) begin
                    check("rd_latency", $time, exp_t);
                    check("rd_addr", 64'(bus_if.if_addr_out), 64'(rd_addr_q.pop_front()));
                end
            end
        end
        if (bus_if.if_out_valid) begin
            if (wr_addr_q.size() == 0) begin
                check("wr_strobe_unexpected", 64'(bus_if.if_out_valid), 64'd0);
            end else begin
                check("wr_addr", 64'(bus_if.if_addr_out), 64'(wr_addr_q.pop_front()));
                check("wr_data", 64'(bus_if.if_data_out), 64'(wr_data_q.pop_front()));
                check("wr_latency", $time, wr_t_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0]  ra;
        logic [31:0] rd;
        bus_if.rx_valid   = 1'b0;
        bus_if.rx_data    = 8'd0;
        bus_if.if_data_in = 32'd0;
        last_t            = 64'd0;
        reset             = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_all_zero("reset");

        // write packet
        send_write(8'h05, 32'hDEAD_BEEF, 0);
        wait_idle("t1");
        repeat (5) step();
        check("t1_addr_hold", 64'(bus_if.if_addr_out), 64'h05);
        check("t1_data_hold", 64'(bus_if.if_data_out), 64'hDEAD_BEEF);

        // read packet
        send_read(8'h0A, 32'h1234_5678);
        wait_idle("t2");
        check("t2_tx_data_hold", 64'(bus_if.tx_data), 64'h78);

        // long TX back-pressure
        busy_len = 100;
        send_read(8'h33, 32'hA5C3_0F96);
        wait_idle("t3");
        busy_len = 3;

        // junk bytes in IDLE, then bytes injected while a read is in flight
        send_byte(8'h00);
        send_byte(8'hFF);
        send_write(8'h7F, 32'h0102_0304, 0);
        wait_idle("t4a");
        busy_len = 20;
        send_read(8'h0B, 32'hCAFE_F00D);
        send_byte(8'h57);
        send_byte(8'h52);
        repeat (10) step();
        send_byte(8'h57);
        send_byte(8'h05);
        send_byte(8'h52);
        wait_idle("t4b");
        check("t4_addr_hold", 64'(bus_if.if_addr_out), 64'h0B);
        busy_len = 3;

        // random writes and reads
        for (int i = 0; i < 3; i++) begin
            ra = 8'($urandom_range(0, 255));
            rd = $urandom;
            send_write(ra, rd, $urandom_range(0, 3));
            wait_idle("rand_wr");
            ra = 8'($urandom_range(0, 255));
            rd = $urandom;
            send_read(ra, rd);
            wait_idle("rand_rd");
        end

        // timeout mid-packet, then packets with gaps below the timeout
        send_byte(8'h57);
        send_byte(8'h05);
        send_byte(8'h11);
        repeat (20) step();
        check("t5_state_idle", 64'(state_dbg), 64'd0);
        check("t5_busy", 64'(bus_if.busy), 64'd0);
        send_write(8'h05, 32'hDEAD_BEEF, 0);
        wait_idle("t5a");
        send_write(8'h06, 32'h5555_AAAA, 12);
        wait_idle("t5b");

        // reset mid-packet
        send_byte(8'h57);
        send_byte(8'h05);
        send_byte(8'hAA);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("t6");
        reset = 1'b0;
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        wait_idle("t6");
        check("t6_data_after", 64'(bus_if.if_data_out), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
